// File: rtl/vga_hvsync_generator.sv
// 640x480@60 VGA raster timing: free-running pixel/line counters with
// active-low sync pulses and a visible-area flag, all aligned to hpos/vpos.
module vga_hvsync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [9:0] h_next;
  logic [9:0] v_next;

  always_comb begin
    h_next = hpos + 10'd1;
    v_next = vpos;
    if (reset) begin
      h_next = '0;
      v_next = '0;
    end else if (hpos == H_MAX) begin
      h_next = '0;
      v_next = (vpos == V_MAX) ? 10'd0 : vpos + 10'd1;
    end
  end

  // Decodes are registered from the next counter values so every output is
  // glitch-free yet describes the same (hpos, vpos) as the counter registers.
  always_ff @(posedge clk) begin
    hpos       <= h_next;
    vpos       <= v_next;
    hsync      <= !((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END));
    vsync      <= !((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END));
    display_on <= (h_next < H_VIS) && (v_next < V_VIS);
  end

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator: full-size instance for reset/line timing,
// a shrunken-parameter instance so whole frames fit in a short run.
module tb_vga_hvsync_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_s = 1'b1;
  logic       hsync_b, vsync_b, de_b;
  logic [9:0] hpos_b, vpos_b;
  logic       hsync_s, vsync_s, de_s;
  logic [9:0] hpos_s, vpos_s;

  logic [22:0] exp_q[$];
  logic [22:0] got, exp_v;
  int n_pass = 0;
  int n_checks = 0;
  int t_b = 0;
  int t_s = 0;

  always #20 clk = ~clk;

  vga_hvsync_generator dut (
    .clk(clk), .reset(reset), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(de_b), .hpos(hpos_b), .vpos(vpos_b)
  );

  // Small raster: 15 clocks/line (sync 10..12), 13 lines/frame (vsync 8..9).
  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
  ) dut_s (
    .clk(clk), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(de_s), .hpos(hpos_s), .vpos(vpos_s)
  );

  // Expected state as a function of clocks since reset: {hpos,vpos,hs,vs,de}
  function automatic logic [22:0] model_big(input int t);
    int h, v;
    logic hs, vs, de;
    h  = t % 800;
    v  = (t / 800) % 525;
    hs = !(h >= 656 && h <= 751);
    vs = !(v >= 490 && v <= 491);
    de = (h < 640) && (v < 480);
    return {10'(h), 10'(v), hs, vs, de};
  endfunction

  function automatic logic [22:0] model_small(input int t);
    int h, v;
    logic hs, vs, de;
    h  = t % 15;
    v  = (t / 15) % 13;
    hs = !(h >= 10 && h <= 12);
    vs = !(v >= 8 && v <= 9);
    de = (h < 8) && (v < 6);
    return {10'(h), 10'(v), hs, vs, de};
  endfunction

  // One clock of stimulus: push the expected state, then move to the sample point.
  task automatic advance_big();
    @(posedge clk);
    t_b = reset ? 0 : t_b + 1;
    exp_q.push_back(model_big(t_b));
    @(negedge clk);
  endtask

  task automatic advance_small();
    @(posedge clk);
    t_s = reset_s ? 0 : t_s + 1;
    exp_q.push_back(model_small(t_s));
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance_big();
      exp_v = exp_q.pop_front();
      got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
      n_checks++;
      if (got !== exp_v) $display("FAIL reset_hold cyc=%0d actual=%h expected=%h", i, got, exp_v);
      else n_pass++;
    end
    n_checks++;
    if ({hpos_b, vpos_b, hsync_b, vsync_b, de_b} !== {10'd0, 10'd0, 3'b111})
      $display("FAIL reset_values actual h=%0d v=%0d hs=%b vs=%b de=%b required 0 0 1 1 1",
               hpos_b, vpos_b, hsync_b, vsync_b, de_b);
    else n_pass++;
    reset = 1'b0;
    advance_big();
    exp_v = exp_q.pop_front();
    got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
    n_checks++;
    if (got !== exp_v) $display("FAIL reset_release actual=%h expected=%h", got, exp_v);
    else n_pass++;
    n_checks++;
    if (hpos_b !== 10'd1) $display("FAIL first_step actual hpos=%0d required 1", hpos_b);
    else n_pass++;
  endtask

  task automatic test_line_timing();
    int de_fall_h, hs_fall_h, hs_rise_h;
    logic prev_de, prev_hs;
    de_fall_h = -1; hs_fall_h = -1; hs_rise_h = -1;
    reset = 1'b1;
    advance_big();
    void'(exp_q.pop_front());
    reset = 1'b0;
    prev_de = de_b; prev_hs = hsync_b;
    for (int i = 0; i < 800; i++) begin
      advance_big();
      exp_v = exp_q.pop_front();
      got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
      n_checks++;
      if (got !== exp_v) $display("FAIL line_sb t=%0d actual=%h expected=%h", t_b, got, exp_v);
      else n_pass++;
      if (prev_de && !de_b && de_fall_h < 0) de_fall_h = int'(hpos_b);
      if (prev_hs && !hsync_b && hs_fall_h < 0) hs_fall_h = int'(hpos_b);
      if (!prev_hs && hsync_b && hs_rise_h < 0) hs_rise_h = int'(hpos_b);
      prev_de = de_b; prev_hs = hsync_b;
    end
    n_checks++;
    if (de_fall_h != 640) $display("FAIL de_fall actual hpos=%0d required 640", de_fall_h);
    else n_pass++;
    n_checks++;
    if (hs_fall_h != 656) $display("FAIL hsync_fall actual hpos=%0d required 656", hs_fall_h);
    else n_pass++;
    n_checks++;
    if (hs_rise_h != 752) $display("FAIL hsync_rise actual hpos=%0d required 752", hs_rise_h);
    else n_pass++;
    n_checks++;
    if (hpos_b !== 10'd0 || vpos_b !== 10'd1)
      $display("FAIL line_wrap actual (%0d,%0d) required (0,1)", hpos_b, vpos_b);
    else n_pass++;
  endtask

  task automatic test_multi_line();
    int pulses, bad_len, run;
    pulses = 0; bad_len = 0; run = 0;
    for (int i = 0; i < 39 * 800; i++) begin
      advance_big();
      exp_v = exp_q.pop_front();
      got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
      n_checks++;
      if (got !== exp_v) $display("FAIL multi_line_sb t=%0d actual=%h expected=%h", t_b, got, exp_v);
      else n_pass++;
      if (!hsync_b) run++;
      else if (run > 0) begin
        pulses++;
        if (run != 96) bad_len++;
        run = 0;
      end
    end
    n_checks++;
    if (pulses != 39 || bad_len != 0)
      $display("FAIL hsync_pulses actual count=%0d bad_len=%0d required 39 0", pulses, bad_len);
    else n_pass++;
  endtask

  task automatic test_mid_line_reset();
    int guard;
    guard = 0;
    while (hpos_b != 10'd700 && guard < 1000) begin
      advance_big();
      void'(exp_q.pop_front());
      guard++;
    end
    n_checks++;
    if (hpos_b !== 10'd700) $display("FAIL reach_700 actual hpos=%0d required 700", hpos_b);
    else n_pass++;
    reset = 1'b1;
    advance_big();
    reset = 1'b0;
    exp_v = exp_q.pop_front();
    got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
    n_checks++;
    if (got !== exp_v) $display("FAIL mid_reset actual=%h expected=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 800; i++) begin
      advance_big();
      exp_v = exp_q.pop_front();
      got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
      n_checks++;
      if (got !== exp_v) $display("FAIL post_reset_sb t=%0d actual=%h expected=%h", t_b, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_frame_small();
    int hs_p, hs_bad, hs_run, vs_p, vs_bad, vs_run, de_cnt, de_bad, wrap_bad;
    hs_p = 0; hs_bad = 0; hs_run = 0; vs_p = 0; vs_bad = 0; vs_run = 0;
    de_cnt = 0; de_bad = 0; wrap_bad = 0;
    reset_s = 1'b1;
    advance_small();
    void'(exp_q.pop_front());
    reset_s = 1'b0;
    if (de_s) de_cnt++;
    for (int i = 0; i < 3 * 195; i++) begin
      advance_small();
      exp_v = exp_q.pop_front();
      got = {hpos_s, vpos_s, hsync_s, vsync_s, de_s};
      n_checks++;
      if (got !== exp_v) $display("FAIL frame_sb t=%0d actual=%h expected=%h", t_s, got, exp_v);
      else n_pass++;
      if (i < 3 * 195 - 1 && de_s) de_cnt++;
      if (de_s && vpos_s >= 10'd6) de_bad++;
      if ((t_s % 195) == 0 && (hpos_s !== 10'd0 || vpos_s !== 10'd0)) wrap_bad++;
      if (!hsync_s) hs_run++;
      else if (hs_run > 0) begin hs_p++; if (hs_run != 3) hs_bad++; hs_run = 0; end
      if (!vsync_s) vs_run++;
      else if (vs_run > 0) begin vs_p++; if (vs_run != 30) vs_bad++; vs_run = 0; end
    end
    n_checks++;
    if (hs_p != 39 || hs_bad != 0)
      $display("FAIL small_hsync_pulses actual=%0d bad=%0d required 39 0", hs_p, hs_bad);
    else n_pass++;
    n_checks++;
    if (vs_p != 3 || vs_bad != 0)
      $display("FAIL small_vsync_pulses actual=%0d bad=%0d required 3 0", vs_p, vs_bad);
    else n_pass++;
    n_checks++;
    if (de_cnt != 144 || de_bad != 0)
      $display("FAIL small_display_on actual=%0d bad=%0d required 144 0", de_cnt, de_bad);
    else n_pass++;
    n_checks++;
    if (wrap_bad != 0) $display("FAIL small_frame_period actual bad=%0d required 0", wrap_bad);
    else n_pass++;
  endtask

  task automatic test_frame_wrap_small();
    int guard;
    guard = 0;
    while (!(hpos_s == 10'd14 && vpos_s == 10'd12) && guard < 400) begin
      advance_small();
      void'(exp_q.pop_front());
      guard++;
    end
    n_checks++;
    if (hpos_s !== 10'd14 || vpos_s !== 10'd12)
      $display("FAIL reach_last actual (%0d,%0d) required (14,12)", hpos_s, vpos_s);
    else n_pass++;
    advance_small();
    void'(exp_q.pop_front());
    n_checks++;
    if ({hpos_s, vpos_s, hsync_s, vsync_s, de_s} !== {10'd0, 10'd0, 3'b111})
      $display("FAIL frame_wrap actual h=%0d v=%0d hs=%b vs=%b de=%b required 0 0 1 1 1",
               hpos_s, vpos_s, hsync_s, vsync_s, de_s);
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset_small();
    int guard;
    guard = 0;
    while (!(hpos_s == 10'd11 && vpos_s == 10'd8) && guard < 400) begin
      advance_small();
      void'(exp_q.pop_front());
      guard++;
    end
    n_checks++;
    if (vsync_s !== 1'b0 || hsync_s !== 1'b0 || hpos_s !== 10'd11)
      $display("FAIL in_sync actual h=%0d hs=%b vs=%b required 11 0 0", hpos_s, hsync_s, vsync_s);
    else n_pass++;
    reset_s = 1'b1;
    advance_small();
    reset_s = 1'b0;
    exp_v = exp_q.pop_front();
    got = {hpos_s, vpos_s, hsync_s, vsync_s, de_s};
    n_checks++;
    if (got !== exp_v) $display("FAIL small_mid_reset actual=%h expected=%h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 195; i++) begin
      advance_small();
      exp_v = exp_q.pop_front();
      got = {hpos_s, vpos_s, hsync_s, vsync_s, de_s};
      n_checks++;
      if (got !== exp_v) $display("FAIL small_post_reset_sb t=%0d actual=%h expected=%h", t_s, got, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (hpos_s !== 10'd0 || vpos_s !== 10'd0)
      $display("FAIL small_post_reset_wrap actual (%0d,%0d) required (0,0)", hpos_s, vpos_s);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_multi_line();
    test_mid_line_reset();
    test_frame_small();
    test_frame_wrap_small();
    test_mid_frame_reset_small();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain actual=%0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
